// File: rtl/io_bus_atomic_mh.sv
// Multi-hart LR/SC reservation and AMO lock gate between the CPU Wishbone port and the IO bus.
// Each hart holds one reservation; the single AMO lock is guarded by a watchdog.
module io_bus_atomic_mh #(
    parameter  int NUM_HARTS    = 2,
    parameter  int GRANULE_LOG2 = 2,
    parameter  int RSV_TIMEOUT  = 1024,
    parameter  int LOCK_TIMEOUT = 256,
    parameter  int DEV_ADDR_W   = 24,
    localparam int HART_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [2:0]            addr_tag_i,
    input  logic [HART_W-1:0]     hart_id_i,
    input  logic [31:0]           data_i,
    input  logic [3:0]            sel_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [31:0]           data_o,
    output logic                  data_tag_o,
    output logic                  dev_stb_o,
    output logic                  dev_cyc_o,
    output logic [DEV_ADDR_W-1:0] dev_addr_o,
    output logic [31:0]           dev_data_o,
    output logic [3:0]            dev_sel_o,
    output logic                  dev_we_o,
    input  logic                  dev_ack_i,
    input  logic                  dev_err_i,
    input  logic [31:0]           dev_data_i,
    output logic [NUM_HARTS-1:0]  rsv_valid_o,
    output logic                  lock_timeout_o
);

    localparam int GW  = 32 - GRANULE_LOG2;
    localparam int RAW = (RSV_TIMEOUT > 1) ? $clog2(RSV_TIMEOUT) : 1;
    localparam int LAW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [RAW-1:0] RSV_LAST  = RAW'(RSV_TIMEOUT - 1);
    localparam logic [LAW-1:0] LOCK_LAST = LAW'(LOCK_TIMEOUT - 1);

    logic [NUM_HARTS-1:0] r_rsv_vld;
    logic [GW-1:0]        r_rsv_gran [NUM_HARTS];
    logic [RAW-1:0]       r_rsv_age  [NUM_HARTS];
    logic                 r_lock_vld;
    logic [HART_W-1:0]    r_lock_owner;
    logic [GW-1:0]        r_lock_gran;
    logic [LAW-1:0]       r_lock_age;
    logic                 r_lock_to;
    logic                 r_local_ack;
    logic                 r_local_err;

    logic                 w_req;
    logic [1:0]           w_mode;
    logic                 w_lock_bit;
    logic [GW-1:0]        w_gran;
    logic                 w_is_lr;
    logic                 w_is_sc;
    logic                 w_is_amo_l;
    logic                 w_is_amo_u;
    logic                 w_bad;
    logic                 w_plain;
    logic [NUM_HARTS-1:0] w_own;
    logic [NUM_HARTS-1:0] w_match;
    logic [NUM_HARTS-1:0] w_rsv_exp;
    logic                 w_sc_pass;
    logic                 w_sc_fail;
    logic                 w_lock_other;
    logic                 w_blocked;
    logic                 w_amo_stall;
    logic                 w_fwd;
    logic                 w_dack;
    logic                 w_clr_gran;
    logic                 w_sc_done;
    logic                 w_lock_exp;

    assign w_req      = stb_i & cyc_i & ~rst_i;
    assign w_mode     = addr_tag_i[2:1];
    assign w_lock_bit = addr_tag_i[0];
    assign w_gran     = addr_i[31:GRANULE_LOG2];

    assign w_is_lr    = (w_mode == 2'b01) & w_lock_bit & ~we_i;
    assign w_is_sc    = (w_mode == 2'b01) & ~w_lock_bit & we_i;
    assign w_is_amo_l = (w_mode == 2'b10) & w_lock_bit;
    assign w_is_amo_u = (w_mode == 2'b10) & ~w_lock_bit;
    assign w_bad      = (w_mode == 2'b11);
    assign w_plain    = ~w_is_lr & ~w_is_sc & ~w_is_amo_l & ~w_is_amo_u & ~w_bad;

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_own[h]     = (hart_id_i == HART_W'(h));
            w_match[h]   = r_rsv_vld[h] & (r_rsv_gran[h] == w_gran);
            w_rsv_exp[h] = (RSV_TIMEOUT != 0) & r_rsv_vld[h] &
                           (r_rsv_age[h] == RSV_LAST);
        end
    end

    // A reservation in its last live cycle cannot back a successful SC.
    assign w_sc_pass    = |(w_own & w_match & ~w_rsv_exp);
    assign w_sc_fail    = w_is_sc & ~w_sc_pass;
    assign w_lock_other = r_lock_vld & (r_lock_owner != hart_id_i);
    assign w_blocked    = w_lock_other & (r_lock_gran == w_gran);
    assign w_amo_stall  = w_is_amo_l & w_lock_other;
    assign w_fwd        = w_req & ~w_bad & ~w_blocked & ~w_sc_fail & ~w_amo_stall;
    assign w_dack       = w_fwd & dev_ack_i & ~dev_err_i;
    assign w_clr_gran   = w_dack & ((w_plain & we_i) | w_is_sc | w_is_amo_u);
    assign w_sc_done    = w_is_sc & (w_dack | (w_req & r_local_ack));
    assign w_lock_exp   = (LOCK_TIMEOUT != 0) & r_lock_vld & (r_lock_age == LOCK_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsv_vld    <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_rsv_gran[h] <= '0;
                r_rsv_age[h]  <= '0;
            end
            r_lock_vld   <= 1'b0;
            r_lock_owner <= '0;
            r_lock_gran  <= '0;
            r_lock_age   <= '0;
            r_lock_to    <= 1'b0;
            r_local_ack  <= 1'b0;
            r_local_err  <= 1'b0;
        end else begin
            // Later assignments win: ageing, then clears, then a fresh LR.
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (r_rsv_vld[h]) begin
                    if (w_rsv_exp[h])
                        r_rsv_vld[h] <= 1'b0;
                    else if (RSV_TIMEOUT != 0)
                        r_rsv_age[h] <= r_rsv_age[h] + RAW'(1);
                end
                if (w_clr_gran & w_match[h])
                    r_rsv_vld[h] <= 1'b0;
                if (w_sc_done & w_own[h])
                    r_rsv_vld[h] <= 1'b0;
                if (w_dack & w_is_lr & w_own[h]) begin
                    r_rsv_vld[h]  <= 1'b1;
                    r_rsv_gran[h] <= w_gran;
                    r_rsv_age[h]  <= '0;
                end
            end

            r_lock_to <= 1'b0;
            if (r_lock_vld) begin
                if (w_lock_exp) begin
                    r_lock_vld <= 1'b0;
                    r_lock_to  <= 1'b1;
                end else if (LOCK_TIMEOUT != 0) begin
                    r_lock_age <= r_lock_age + LAW'(1);
                end
            end
            if (w_dack & w_is_amo_u & r_lock_vld & (r_lock_owner == hart_id_i))
                r_lock_vld <= 1'b0;
            if (w_dack & w_is_amo_l) begin
                r_lock_vld   <= 1'b1;
                r_lock_owner <= hart_id_i;
                r_lock_gran  <= w_gran;
                r_lock_age   <= '0;
            end

            r_local_ack <= w_req & w_sc_fail & ~w_blocked;
            r_local_err <= w_req & w_bad;
        end
    end

    assign ack_o          = stb_i & ~rst_i & (r_local_ack | (w_fwd & dev_ack_i));
    assign err_o          = stb_i & ~rst_i & (r_local_err | (w_fwd & dev_err_i));
    assign data_tag_o     = stb_i & ~rst_i & r_local_ack;
    assign data_o         = dev_data_i;
    assign dev_stb_o      = w_fwd;
    assign dev_cyc_o      = w_fwd;
    assign dev_addr_o     = addr_i[DEV_ADDR_W-1:0];
    assign dev_data_o     = data_i;
    assign dev_sel_o      = sel_i;
    assign dev_we_o       = we_i;
    assign rsv_valid_o    = r_rsv_vld;
    assign lock_timeout_o = r_lock_to;

endmodule
